// File: rtl/wheel_pulse_gen_if.sv
// Purpose: wheel-pulse bundle between the pulse generator and its consumer (button/speed in, pulse/status out).
// Latency: none, wires only.
// Backpressure: none; the pulse train is free-running and the consumer must keep up.
interface wheel_pulse_gen_if #(
    parameter int SPEED_W = 12
);
    logic               btn_n;
    logic [SPEED_W-1:0] speed_set;
    logic               pulse_n;
    logic [SPEED_W-1:0] cur_speed;
    logic [1:0]         drive_stat;
    logic [19:0]        pulse_total;
    logic               overrun;

    // Generator side: takes button and set speed, drives the pulse train and status.
    modport master (
        input  btn_n,
        input  speed_set,
        output pulse_n,
        output cur_speed,
        output drive_stat,
        output pulse_total,
        output overrun
    );

    // Consumer side: drives button and set speed, observes pulses and status.
    modport slave (
        output btn_n,
        output speed_set,
        input  pulse_n,
        input  cur_speed,
        input  drive_stat,
        input  pulse_total,
        input  overrun
    );
endinterface

// File: rtl/wheel_pulse_gen.sv
// Purpose: wheel-speed pulse emulator; button-driven idle/drive/wait FSM, ramped speed, phase-accumulator pulse train.
// Latency: button edge to drive_stat 3 sys_clk; fire request to pulse_n low 1 sys_clk.
// Backpressure: none; one request is queued while a pulse is active, further requests are dropped and flagged in overrun.
module wheel_pulse_gen #(
    parameter int ACC_MOD     = 50_000_000,
    parameter int SPEED_W     = 12,
    parameter int PULSE_LOW   = 8,
    parameter int RAMP_CYCLES = 50_000,
    parameter int RAMP_STEP   = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    wheel_pulse_gen_if.master bus
);

    localparam int ACC_W  = $clog2(ACC_MOD + (1 << SPEED_W));
    localparam int RAMP_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam int LOW_W  = (PULSE_LOW > 1) ? $clog2(PULSE_LOW) : 1;

    localparam logic [ACC_W-1:0]   ACC_MOD_X  = ACC_W'(ACC_MOD);
    localparam logic [SPEED_W:0]   STEP_X     = (SPEED_W+1)'(RAMP_STEP);
    localparam logic [RAMP_W-1:0]  RAMP_LAST  = RAMP_W'(RAMP_CYCLES - 1);
    localparam logic [LOW_W-1:0]   LOW_LAST   = LOW_W'(PULSE_LOW - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_BAD   = 2'd3
    } drive_e;

    typedef enum logic [1:0] {
        SH_IDLE = 2'd0,
        SH_LOW  = 2'd1,
        SH_GAP  = 2'd2
    } shape_e;

    // ---------------- button synchroniser and press detect ----------------
    logic btn_s1, btn_s2, btn_s3;
    logic press;

    // Two-flop synchroniser plus one delay flop for falling-edge detection; idle level is high.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            btn_s1 <= 1'b1;
            btn_s2 <= 1'b1;
            btn_s3 <= 1'b1;
        end else begin
            btn_s1 <= bus.btn_n;
            btn_s2 <= btn_s1;
            btn_s3 <= btn_s2;
        end
    end

    assign press = btn_s3 & ~btn_s2;

    // ---------------- drive FSM ----------------
    drive_e drive_q, drive_d;

    // Drive state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) drive_q <= ST_IDLE;
        else            drive_q <= drive_d;
    end

    // One transition per press; idle is left for good, drive and wait alternate, code 3 recovers to idle.
    always_comb begin
        drive_d = drive_q;
        case (drive_q)
            ST_IDLE:  if (press) drive_d = ST_DRIVE;
            ST_DRIVE: if (press) drive_d = ST_WAIT;
            ST_WAIT:  if (press) drive_d = ST_DRIVE;
            default:  drive_d = ST_IDLE;
        endcase
    end

    // ---------------- speed ramp ----------------
    logic [RAMP_W-1:0]  ramp_cnt;
    logic               ramp_tick;
    logic [SPEED_W-1:0] target;
    logic [SPEED_W-1:0] cur_q, cur_d;
    logic [SPEED_W:0]   diff;

    assign ramp_tick = (ramp_cnt == RAMP_LAST);
    assign target    = (drive_q == ST_DRIVE) ? bus.speed_set : '0;

    // Free-running ramp timer; the tick is the cycle the counter wraps.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)     ramp_cnt <= '0;
        else if (ramp_tick) ramp_cnt <= '0;
        else                ramp_cnt <= ramp_cnt + RAMP_W'(1);
    end

    // Next ramp value: one step toward target, snapping onto it when closer than a step.
    always_comb begin
        cur_d = cur_q;
        diff  = '0;
        if (target > cur_q) begin
            diff = {1'b0, target} - {1'b0, cur_q};
            if (diff < STEP_X) cur_d = target;
            else               cur_d = cur_q + STEP_X[SPEED_W-1:0];
        end else if (target < cur_q) begin
            diff = {1'b0, cur_q} - {1'b0, target};
            if (diff < STEP_X) cur_d = target;
            else               cur_d = cur_q - STEP_X[SPEED_W-1:0];
        end
    end

    // Current speed only moves on a ramp tick, so a speed_set change takes effect at the next tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)     cur_q <= '0;
        else if (ramp_tick) cur_q <= cur_d;
    end

    // ---------------- phase accumulator ----------------
    logic [ACC_W-1:0] acc_q, acc_sum;
    logic             fire;

    // acc stays below ACC_MOD, so one subtraction is enough and a zero speed leaves it untouched.
    assign acc_sum = acc_q + {{(ACC_W-SPEED_W){1'b0}}, cur_q};
    assign fire    = (acc_sum >= ACC_MOD_X);

    // Accumulator register; deliberately not cleared on drive-state changes.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) acc_q <= '0;
        else if (fire)  acc_q <= acc_sum - ACC_MOD_X;
        else            acc_q <= acc_sum;
    end

    // ---------------- pulse shaper ----------------
    shape_e           sh_q, sh_d;
    logic [LOW_W-1:0] low_cnt_q, low_cnt_d;
    logic             pend_q, pend_d;
    logic             ovr_q, ovr_d;
    logic             pulse_n_q;
    logic [19:0]      total_q;

    // Shaper: LOW for PULSE_LOW cycles, one mandatory GAP cycle, then a queued request may start at once.
    always_comb begin
        sh_d      = sh_q;
        low_cnt_d = low_cnt_q;
        pend_d    = pend_q;
        ovr_d     = ovr_q;
        case (sh_q)
            SH_IDLE: begin
                if (fire) begin
                    sh_d      = SH_LOW;
                    low_cnt_d = '0;
                end
            end
            SH_LOW: begin
                if (low_cnt_q == LOW_LAST) sh_d = SH_GAP;
                else                       low_cnt_d = low_cnt_q + LOW_W'(1);
                if (fire) begin
                    if (pend_q) ovr_d  = 1'b1;
                    else        pend_d = 1'b1;
                end
            end
            SH_GAP: begin
                if (pend_q) begin
                    // The queued pulse starts now; a fresh request meets a full queue and is lost.
                    sh_d      = SH_LOW;
                    low_cnt_d = '0;
                    pend_d    = 1'b0;
                    if (fire) ovr_d = 1'b1;
                end else if (fire) begin
                    sh_d      = SH_LOW;
                    low_cnt_d = '0;
                end else begin
                    sh_d = SH_IDLE;
                end
            end
            default: sh_d = SH_IDLE;
        endcase
    end

    // Shaper state and registered outputs; pulse_total counts entries into the low phase.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sh_q      <= SH_IDLE;
            low_cnt_q <= '0;
            pend_q    <= 1'b0;
            ovr_q     <= 1'b0;
            pulse_n_q <= 1'b1;
            total_q   <= '0;
        end else begin
            sh_q      <= sh_d;
            low_cnt_q <= low_cnt_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            pulse_n_q <= (sh_d != SH_LOW);
            if (sh_d == SH_LOW && sh_q != SH_LOW) total_q <= total_q + 20'd1;
        end
    end

    assign bus.pulse_n     = pulse_n_q;
    assign bus.cur_speed   = cur_q;
    assign bus.drive_stat  = drive_q;
    assign bus.pulse_total = total_q;
    assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_wheel_pulse_gen.sv
// Purpose: self-checking bench for wheel_pulse_gen (step 1 and step 3 instances) against an interval-based reference model.
// Latency: model advanced at each rising edge, outputs compared at the following falling edge.
// Backpressure: not applicable; inputs are driven at falling edges.
module tb_wheel_pulse_gen;

    localparam int M = 100;
    localparam int L = 4;
    localparam int R = 10;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        btn_n = 1'b1;
    logic [11:0] speed_set = 12'd10;

    int vectors = 0;
    int miscompares = 0;

    always #5 sys_clk = ~sys_clk;

    wheel_pulse_gen_if #(.SPEED_W(12)) bus1 ();
    wheel_pulse_gen_if #(.SPEED_W(12)) bus2 ();

    assign bus1.btn_n     = btn_n;
    assign bus1.speed_set = speed_set;
    assign bus2.btn_n     = btn_n;
    assign bus2.speed_set = speed_set;

    wheel_pulse_gen #(.ACC_MOD(M), .SPEED_W(12), .PULSE_LOW(L), .RAMP_CYCLES(R), .RAMP_STEP(1)) dut1 (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus1)
    );

    wheel_pulse_gen #(.ACC_MOD(M), .SPEED_W(12), .PULSE_LOW(L), .RAMP_CYCLES(R), .RAMP_STEP(3)) dut2 (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus2)
    );

    // Reference model: edge counter, scheduled press time, speed, phase, and pulse intervals.
    typedef struct {
        int e;          // rising edges since reset release
        int prev_btn;   // btn_n seen at the previous edge
        int due;        // edge at which a detected press changes the state, -1 if none
        int st;         // 0 idle, 1 wait, 2 drive
        int cur;
        int acc;
        int next_free;  // earliest edge a new pulse may start
        int low_until;  // last edge after which pulse_n is low
        int pend;
        int total;
        int ovr;
        int pn;
    } model_t;

    model_t m1, m2;

    function automatic model_t mreset();
        model_t n;
        n.e = 0; n.prev_btn = 1; n.due = -1; n.st = 0; n.cur = 0; n.acc = 0;
        n.next_free = 0; n.low_until = -1; n.pend = 0; n.total = 0; n.ovr = 0; n.pn = 1;
        return n;
    endfunction

    function automatic model_t mstep(model_t m, int btn, int spd, int step, int rst_n);
        model_t n;
        int tgt, sum, fire, start;
        if (rst_n == 0) return mreset();
        n = m;
        tgt = (m.st == 2) ? spd : 0;
        sum = m.acc + m.cur;
        fire = (sum >= M) ? 1 : 0;
        n.acc = fire ? sum - M : sum;
        if (m.e % R == R - 1) begin
            if (tgt > m.cur)      n.cur = (m.cur + step > tgt) ? tgt : m.cur + step;
            else if (tgt < m.cur) n.cur = (m.cur - step < tgt) ? tgt : m.cur - step;
        end
        start = 0;
        if (m.e >= m.next_free) begin
            if (m.pend != 0) begin
                start = 1; n.pend = 0;
                if (fire != 0) n.ovr = 1;
            end else if (fire != 0) begin
                start = 1;
            end
        end else if (fire != 0) begin
            if (m.pend != 0) n.ovr = 1;
            else             n.pend = 1;
        end
        if (start != 0) begin
            n.next_free = m.e + L + 1;
            n.low_until = m.e + L - 1;
            n.total     = (m.total + 1) % (1 << 20);
        end
        n.pn = (n.low_until >= m.e) ? 0 : 1;
        if (m.due == m.e) begin
            n.st  = (m.st == 2) ? 1 : 2;
            n.due = -1;
        end
        if (m.prev_btn == 1 && btn == 0) n.due = m.e + 2;
        n.prev_btn = btn;
        n.e = m.e + 1;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pulse_n_s1",   32'(bus1.pulse_n),     32'(m1.pn));
        chk("cur_speed_s1", 32'(bus1.cur_speed),   32'(m1.cur));
        chk("drive_s1",     32'(bus1.drive_stat),  32'(m1.st));
        chk("total_s1",     32'(bus1.pulse_total), 32'(m1.total));
        chk("overrun_s1",   32'(bus1.overrun),     32'(m1.ovr));
        chk("pulse_n_s3",   32'(bus2.pulse_n),     32'(m2.pn));
        chk("cur_speed_s3", 32'(bus2.cur_speed),   32'(m2.cur));
        chk("drive_s3",     32'(bus2.drive_stat),  32'(m2.st));
        chk("total_s3",     32'(bus2.pulse_total), 32'(m2.total));
        chk("overrun_s3",   32'(bus2.overrun),     32'(m2.ovr));
    endtask

    // Advance n clocks: model updated at the rising edge, DUTs compared at the falling edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            m1 = mstep(m1, int'(btn_n), int'(speed_set), 1, int'(sys_rst_n));
            m2 = mstep(m2, int'(btn_n), int'(speed_set), 3, int'(sys_rst_n));
            @(negedge sys_clk);
            check_all();
        end
    endtask

    task automatic press(input int hold);
        btn_n = 1'b0;
        cyc(hold);
        btn_n = 1'b1;
        cyc(10);
    endtask

    initial begin
        int t0;
        int found;
        int prev_pn;
        m1 = mreset();
        m2 = mreset();

        // 1. reset held, then a long idle stretch with no pulses
        @(negedge sys_clk);
        cyc(5);
        chk("rst_pulse_n", 32'(bus1.pulse_n), 32'd1);
        chk("rst_drive",   32'(bus1.drive_stat), 32'd0);
        sys_rst_n = 1'b1;
        cyc(1000);
        chk("idle_total", 32'(bus1.pulse_total), 32'd0);

        // 2. first press: drive after exactly 3 clocks, single transition despite long hold
        btn_n = 1'b0;
        cyc(2);
        chk("press_lat2", 32'(bus1.drive_stat), 32'd0);
        cyc(1);
        chk("press_lat3", 32'(bus1.drive_stat), 32'd2);
        cyc(47);
        btn_n = 1'b1;
        cyc(60);
        chk("ramp_up_10", 32'(bus1.cur_speed), 32'd10);
        t0 = m1.total;
        cyc(1000);
        chk("rate_total", 32'((int'(bus1.pulse_total) - t0 >= 99) && (int'(bus1.pulse_total) - t0 <= 101)), 32'd1);

        // 3. wait: ramp to zero, then pulses stop; third press resumes driving
        press(20);
        chk("wait_state", 32'(bus1.drive_stat), 32'd1);
        cyc(110);
        chk("ramp_down_0", 32'(bus1.cur_speed), 32'd0);
        t0 = m1.total;
        cyc(100);
        chk("frozen_total", 32'(bus1.pulse_total), 32'(t0));
        press(15);
        chk("redrive_state", 32'(bus1.drive_stat), 32'd2);

        // 5. retarget mid-ramp at 7 toward 4; step-3 instance snaps 5 -> 4
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            cyc(1);
            if (m1.cur == 7) found = 1;
        end
        chk("reach_7", 32'(found), 32'd1);
        speed_set = 12'd4;
        cyc(60);
        chk("retarget_s1", 32'(bus1.cur_speed), 32'd4);
        chk("retarget_s3", 32'(bus2.cur_speed), 32'd4);
        speed_set = 12'd5;
        cyc(30);
        chk("step3_to_5", 32'(bus2.cur_speed), 32'd5);
        speed_set = 12'd4;
        cyc(15);
        chk("step3_to_4", 32'(bus2.cur_speed), 32'd4);

        // 4. over-rate request: low phases stay exact and overrun latches
        speed_set = 12'd30;
        cyc(500);
        chk("overrun_s1_set", 32'(bus1.overrun), 32'd1);
        chk("overrun_s3_set", 32'(bus2.overrun), 32'd1);

        // randomized speeds and presses
        for (int k = 0; k < 30; k++) begin
            speed_set = 12'($urandom_range(0, 60));
            if ($urandom_range(0, 2) == 0) press(int'($urandom_range(5, 40)));
            cyc(int'($urandom_range(5, 200)));
        end
        chk("overrun_sticky", 32'(bus1.overrun), 32'd1);

        // 6. reset in the second low cycle of a pulse
        speed_set = 12'd20;
        for (int k = 0; k < 3; k++) begin
            if (m1.st != 2) press(10);
        end
        cyc(300);
        found = 0;
        prev_pn = m1.pn;
        for (int i = 0; i < 300 && found == 0; i++) begin
            cyc(1);
            if (m1.pn == 0 && prev_pn == 1) found = 1;
            prev_pn = m1.pn;
        end
        chk("find_pulse", 32'(found), 32'd1);
        cyc(1);
        chk("second_low", 32'(bus1.pulse_n), 32'd0);
        sys_rst_n = 1'b0;
        #1;
        m1 = mreset();
        m2 = mreset();
        chk("async_pulse_n", 32'(bus1.pulse_n),     32'd1);
        chk("async_cur",     32'(bus1.cur_speed),   32'd0);
        chk("async_drive",   32'(bus1.drive_stat),  32'd0);
        chk("async_total",   32'(bus1.pulse_total), 32'd0);
        chk("async_ovr",     32'(bus1.overrun),     32'd0);
        @(negedge sys_clk);
        cyc(3);
        sys_rst_n = 1'b1;
        cyc(200);
        chk("post_rst_idle",  32'(bus1.drive_stat),  32'd0);
        chk("post_rst_total", 32'(bus1.pulse_total), 32'd0);
        press(10);
        chk("post_rst_drive", 32'(bus1.drive_stat), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
